// File: rtl/ps2_serial_engine_if.sv
// Client-side command/receive bundle for one PS/2 protocol engine.
interface ps2_serial_engine_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_err, tx_done, tx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_err, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_serial_engine.sv
// Single-channel PS/2 host engine: deserialises device frames, serialises host commands.
// Optional clock-line glitch filter enabled by defining PS2_GLITCH_FILTER_EN.
module ps2_serial_engine #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
`ifdef PS2_GLITCH_FILTER_EN
  , parameter int unsigned FILTER_LEN = 8
`endif
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic ps2_clk_rx,
  input  logic ps2_d_rx,
  output logic ps2_clk_tx,
  output logic ps2_d_tx,
  ps2_serial_engine_if.slave bus
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = 4;

  typedef enum logic [2:0] {IDLE, RX, TX_INHIBIT, TX_DATA, TX_ACK, TX_RELEASE} state_t;

  state_t             state;
  logic               clk_s1, clk_s2, d_s1, d_s2;
  logic               fclk, fclk_d;
  logic               sample_evt;
  logic               timeout;
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [7:0]         rx_shift;
  logic               rx_par;
  logic [8:0]         tx_shift;
  logic               tx_ready_q, rx_valid_q, rx_err_q, tx_done_q, tx_err_q;
  logic [7:0]         rx_data_q;

  // Idle PS/2 lines are high, so synchronisers reset high to avoid a false edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      d_s1   <= 1'b1;
      d_s2   <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_rx;
      clk_s2 <= clk_s1;
      d_s1   <= ps2_d_rx;
      d_s2   <= d_s1;
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
  logic [FILT_W-1:0] filt_cnt;
  logic              fclk_q;

  // Accept a new clock level only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fclk_q   <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == fclk_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
      fclk_q   <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign fclk = fclk_q;
`else
  assign fclk = clk_s2;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) fclk_d <= 1'b1;
    else        fclk_d <= fclk;
  end

  assign sample_evt = fclk_d & ~fclk;
  assign timeout    = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Protocol FSM; cnt doubles as inhibit timer and inter-edge watchdog.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      ps2_clk_tx <= 1'b0;
      ps2_d_tx   <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      cnt        <= '0;
      bit_cnt    <= '0;
      rx_shift   <= 8'h00;
      rx_par     <= 1'b0;
      tx_shift   <= 9'h000;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      cnt        <= sample_evt ? '0 : cnt + 1'b1;

      unique case (state)
        IDLE: begin
          cnt        <= '0;
          bit_cnt    <= '0;
          tx_ready_q <= 1'b1;
          if (bus.tx_valid && tx_ready_q) begin
            tx_shift   <= {~^bus.tx_data, bus.tx_data};
            tx_ready_q <= 1'b0;
            ps2_clk_tx <= 1'b1;
            state      <= TX_INHIBIT;
          end else if (sample_evt && !d_s2) begin
            tx_ready_q <= 1'b0;
            state      <= RX;
          end
        end

        RX: begin
          if (sample_evt) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt < BIT_W'(8)) begin
              rx_shift <= {d_s2, rx_shift[7:1]};
            end else if (bit_cnt == BIT_W'(8)) begin
              rx_par <= d_s2;
            end else begin
              if (d_s2 && (^{rx_shift, rx_par})) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= rx_shift;
              end else begin
                rx_err_q <= 1'b1;
              end
              tx_ready_q <= 1'b1;
              state      <= IDLE;
            end
          end else if (timeout) begin
            rx_err_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            state      <= IDLE;
          end
        end

        TX_INHIBIT: begin
          // Our own clock pull causes edges here; the timer must ignore them.
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
            ps2_clk_tx <= 1'b0;
            ps2_d_tx   <= 1'b1;
            cnt        <= '0;
            bit_cnt    <= '0;
            state      <= TX_DATA;
          end
        end

        TX_DATA: begin
          if (sample_evt) begin
            if (bit_cnt < BIT_W'(9)) begin
              ps2_d_tx <= ~tx_shift[0];
              tx_shift <= {1'b0, tx_shift[8:1]};
              bit_cnt  <= bit_cnt + BIT_W'(1);
            end else begin
              ps2_d_tx <= 1'b0;
              state    <= TX_ACK;
            end
          end else if (timeout) begin
            tx_err_q   <= 1'b1;
            ps2_clk_tx <= 1'b0;
            ps2_d_tx   <= 1'b0;
            tx_ready_q <= 1'b1;
            state      <= IDLE;
          end
        end

        TX_ACK: begin
          if (sample_evt) begin
            if (!d_s2) tx_done_q <= 1'b1;
            else       tx_err_q  <= 1'b1;
            state <= TX_RELEASE;
          end else if (timeout) begin
            tx_err_q   <= 1'b1;
            ps2_clk_tx <= 1'b0;
            ps2_d_tx   <= 1'b0;
            tx_ready_q <= 1'b1;
            state      <= IDLE;
          end
        end

        TX_RELEASE: begin
          if (fclk && d_s2) begin
            tx_ready_q <= 1'b1;
            state      <= IDLE;
          end else if (timeout) begin
            ps2_clk_tx <= 1'b0;
            ps2_d_tx   <= 1'b0;
            tx_ready_q <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_err   = rx_err_q;
  assign bus.tx_done  = tx_done_q;
  assign bus.tx_err   = tx_err_q;

endmodule

// File: tb/tb_ps2_serial_engine.sv
// Self-checking bench for ps2_serial_engine: device model, vector table and event scoreboard.
module tb_ps2_serial_engine;
  localparam int INH     = 60;
  localparam int TMO     = 1500;
  localparam int HALF    = 40;
`ifdef PS2_GLITCH_FILTER_EN
  localparam int FLT     = 8;
`else
  localparam int FLT     = 0;
`endif
  localparam int K_RX_OK  = 0;
  localparam int K_RX_ERR = 1;
  localparam int K_TX_OK  = 2;
  localparam int K_TX_ERR = 3;

  logic Clk, Rst_n;
  logic dev_clk, dev_d;
  logic ps2_clk_rx, ps2_d_rx, ps2_clk_tx, ps2_d_tx;

  ps2_serial_engine_if bus ();

  ps2_serial_engine #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ps2_clk_rx(ps2_clk_rx), .ps2_d_rx(ps2_d_rx),
    .ps2_clk_tx(ps2_clk_tx), .ps2_d_tx(ps2_d_tx),
    .bus(bus)
  );

  // Open-collector wired-AND of host and device drivers.
  assign ps2_clk_rx = dev_clk & ~ps2_clk_tx;
  assign ps2_d_rx   = dev_d & ~ps2_d_tx;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct { int kind; logic [7:0] data; } ev_t;
  typedef struct { logic [7:0] b; logic par_flip; logic stop; int kind; logic [7:0] exp_data; } vec_t;

  ev_t  sb[$];
  vec_t vecs[7];
  int   total = 0, bad = 0;
  int   cyc = 0, hi_cnt = 0, last_fall = 0, ev_cycle = 0;
  logic capture = 1'b0;
  int   cap_n = 0, cap_kind = -1;
  logic [7:0] cap_data = 8'h00;
  logic [7:0] last_good;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) if (ps2_clk_tx) hi_cnt++;

  // Event monitor: pops the scoreboard on every result pulse.
  always @(negedge Clk) begin
    int n, kind;
    ev_t e;
    if (Rst_n) begin
      n = int'(bus.rx_valid) + int'(bus.rx_err) + int'(bus.tx_done) + int'(bus.tx_err);
      if (n > 1) begin
        total++; bad++;
        $display("FAIL pulse_exclusive actual=%0d pulses required=1", n);
      end
      if (n != 0) begin
        kind = bus.rx_valid ? K_RX_OK : bus.rx_err ? K_RX_ERR : bus.tx_done ? K_TX_OK : K_TX_ERR;
        ev_cycle = cyc;
        if (capture) begin
          cap_n++; cap_kind = kind; cap_data = bus.rx_data;
        end else if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event actual=kind%0d required=none", kind);
        end else begin
          e = sb.pop_front();
          check("sb_kind", 32'(kind), 32'(e.kind));
          check("sb_rx_data", 32'(bus.rx_data), 32'(e.data));
        end
      end
    end
  end

  task automatic expect_ev(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind; e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge Clk); n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic dev_send(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                          input int nedges, input logic [10:0] gmask);
    logic [10:0] bits;
    bits = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      dev_d = bits[i];
      repeat (HALF) @(negedge Clk);
      dev_clk = 1'b0; last_fall = cyc;
      repeat (HALF) @(negedge Clk);
      dev_clk = 1'b1;
      if (gmask[i]) begin
        repeat (10) @(negedge Clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge Clk);
        dev_clk = 1'b1;
      end
    end
    repeat (HALF) @(negedge Clk);
    dev_d = 1'b1;
  endtask

  task automatic tx_request(input logic [7:0] b);
    int n = 0;
    while (!bus.tx_ready && n < 2000) begin
      @(negedge Clk); n++;
    end
    check("tx_ready_before_req", 32'(bus.tx_ready), 32'd1);
    bus.tx_data = b; bus.tx_valid = 1'b1; hi_cnt = 0;
    @(negedge Clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic dev_recv(input logic ack, output logic [10:0] wb);
    int n = 0;
    wb = '0;
    while (!(ps2_clk_rx && !ps2_d_rx) && n < 4 * INH + 200) begin
      @(negedge Clk); n++;
    end
    check("tx_start_seen", 32'(n < 4 * INH + 200), 32'd1);
    wb[0] = ps2_d_rx;
    for (int i = 1; i <= 10; i++) begin
      repeat (HALF) @(negedge Clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge Clk);
      dev_clk = 1'b1;
      repeat (HALF / 2) @(negedge Clk);
      wb[i] = ps2_d_rx;
    end
    repeat (HALF / 2) @(negedge Clk);
    dev_d = ack ? 1'b0 : 1'b1;
    repeat (HALF / 2) @(negedge Clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge Clk);
    dev_clk = 1'b1;
    repeat (HALF) @(negedge Clk);
    dev_d = 1'b1;
  endtask

  initial begin
    logic [10:0] wb, exp_wire;
    int delta;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, K_RX_OK,  8'h1C};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, K_RX_ERR, 8'h1C};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, K_RX_ERR, 8'h1C};
    vecs[3] = '{8'h00, 1'b0, 1'b1, K_RX_OK,  8'h00};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, K_RX_OK,  8'hFF};
    vecs[5] = '{8'h81, 1'b1, 1'b1, K_RX_ERR, 8'hFF};
    vecs[6] = '{8'h3C, 1'b0, 1'b1, K_RX_OK,  8'h3C};

    dev_clk = 1'b1; dev_d = 1'b1;
    bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'h00);
    check("rst_clk_tx", 32'(ps2_clk_tx), 32'd0);
    check("rst_d_tx", 32'(ps2_d_tx), 32'd0);
    check("rst_pulses", 32'({bus.rx_valid, bus.rx_err, bus.tx_done, bus.tx_err}), 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("tx_ready_after_rst", 32'(bus.tx_ready), 32'd1);

    // Device-to-host frames from the vector table.
    for (int i = 0; i < 7; i++) begin
      expect_ev(vecs[i].kind, vecs[i].exp_data);
      dev_send(vecs[i].b, vecs[i].par_flip, vecs[i].stop, 11, 11'h000);
      wait_drain(TMO + 500);
      repeat (2 * HALF) @(negedge Clk);
    end
    last_good = vecs[6].exp_data;

    // Host command 0xED, device acks.
    exp_wire = {1'b1, ~^8'hED, 8'hED, 1'b0};
    expect_ev(K_TX_OK, last_good);
    tx_request(8'hED);
    dev_recv(1'b1, wb);
    check("inhibit_cycles", 32'(hi_cnt), 32'(INH));
    check("tx_wire_bits", 32'(wb), 32'(exp_wire));
    wait_drain(TMO + 500);
    repeat (2 * HALF) @(negedge Clk);
    check("tx_ready_after_ack", 32'(bus.tx_ready), 32'd1);

    // Same command, no ack.
    expect_ev(K_TX_ERR, last_good);
    tx_request(8'hED);
    dev_recv(1'b0, wb);
    check("noack_wire_bits", 32'(wb), 32'(exp_wire));
    wait_drain(TMO + 500);
    repeat (2 * HALF) @(negedge Clk);
    check("noack_lines", 32'({ps2_clk_tx, ps2_d_tx}), 32'd0);
    check("noack_tx_ready", 32'(bus.tx_ready), 32'd1);

    // Device never clocks a command: watchdog expiry in TX_DATA.
    expect_ev(K_TX_ERR, last_good);
    tx_request(8'h42);
    wait_drain(INH + TMO + 500);
    @(negedge Clk);
    check("txto_lines", 32'({ps2_clk_tx, ps2_d_tx}), 32'd0);
    check("txto_tx_ready", 32'(bus.tx_ready), 32'd1);

    // Receive watchdog: clock stops after four data bits.
    expect_ev(K_RX_ERR, last_good);
    dev_send(8'h33, 1'b0, 1'b1, 5, 11'h000);
    wait_drain(TMO + 500);
    delta = ev_cycle - last_fall;
    check("rx_timeout_window", 32'(delta >= TMO && delta <= TMO + 4 + FLT), 32'd1);
    repeat (4) @(negedge Clk);
    check("rx_timeout_idle", 32'(bus.tx_ready), 32'd1);
    expect_ev(K_RX_OK, 8'hAA);
    dev_send(8'hAA, 1'b0, 1'b1, 11, 11'h000);
    wait_drain(TMO + 500);
    repeat (2 * HALF) @(negedge Clk);

    // Short low glitches on the clock line during a frame.
    capture = 1'b1; cap_n = 0; cap_kind = -1;
    dev_send(8'hAA, 1'b0, 1'b1, 11, 11'b000_0000_1010);
    repeat (TMO + 200) @(negedge Clk);
    capture = 1'b0;
`ifdef PS2_GLITCH_FILTER_EN
    check("glitch_events", 32'(cap_n), 32'd1);
    check("glitch_kind", 32'(cap_kind), 32'(K_RX_OK));
    check("glitch_data", 32'(cap_data), 32'hAA);
`else
    check("glitch_events", 32'(cap_n >= 1), 32'd1);
    check("glitch_corrupts", 32'(!(cap_kind == K_RX_OK && cap_data == 8'hAA)), 32'd1);
`endif

    // Reset during inhibit releases the lines at once.
    tx_request(8'h11);
    repeat (10) @(negedge Clk);
    check("inhibit_clk_driven", 32'(ps2_clk_tx), 32'd1);
    Rst_n = 1'b0;
    #1;
    check("midrst_lines", 32'({ps2_clk_tx, ps2_d_tx}), 32'd0);
    check("midrst_rx_data", 32'(bus.rx_data), 32'h00);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("midrst_tx_ready", 32'(bus.tx_ready), 32'd1);
    repeat (20) @(negedge Clk);
    check("midrst_lines_idle", 32'({ps2_clk_tx, ps2_d_tx}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_serial_engine.md
Name: ps2_serial_engine

Overview:
- Single-channel PS/2 host-side protocol engine; one instance per port (mouse, keyboard).
- Sits directly upstream of the dual PS/2 pad I/O adapter: consumes that adapter's ps2_clk_rx/ps2_d_rx and drives its ps2_clk_tx/ps2_d_tx, where tx=1 pulls the open-collector line low.
- Deserialises device-to-host frames.
- Serialises host-to-device commands with inhibit, start, parity and ack handling.

Parameters:
- INHIBIT_CYCLES, 5000, clock-low hold before a host transmit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 100000, maximum Clk cycles between PS/2 clock falling edges inside a frame (2 ms at 50 MHz).
- FILTER_LEN, 8, consecutive identical samples needed to accept a PS/2 clock level change.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- ps2_clk_rx  in  1  PS/2 clock line level from the pad adapter.
- ps2_d_rx  in  1  PS/2 data line level from the pad adapter.
- ps2_clk_tx  out  1  1 = drive PS/2 clock low; 0 = release.
- ps2_d_tx  out  1  1 = drive PS/2 data low; 0 = release.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  command request.
- tx_ready  out  1  engine idle; the byte is accepted when tx_valid & tx_ready.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle pulse; rx_data is valid.
- rx_err  out  1  one-cycle pulse on a bad receive: parity, stop bit or timeout.
- tx_done  out  1  one-cycle pulse: device acked the command.
- tx_err  out  1  one-cycle pulse: no ack or timeout during transmit.

Behaviour:
- Reset (async, Rst_n=0):
  - state IDLE.
  - ps2_clk_tx=0, ps2_d_tx=0 (lines released).
  - tx_ready=0, rx_data=0x00, all pulses 0, counters 0.
  - tx_ready is registered; it goes 1 on the first Clk after reset release.
  - Reset mid-frame abandons the frame and releases both lines immediately.
- Input conditioning:
  - Both inputs pass a 2-flop synchroniser.
  - The synchronised clock feeds the glitch filter (see optional feature), giving fclk.
  - A sample event is an fclk 1->0 transition, flagged one cycle after the filter output changes.
  - Data is sampled from the synchronised ps2_d_rx on that same cycle.
- Frame format: start(0), d0..d7 LSB first, odd parity, stop(1).
- States: IDLE, RX, TX_INHIBIT, TX_DATA, TX_ACK, TX_RELEASE.
- IDLE:
  - tx_ready=1.
  - tx_valid=1: latch tx_data, compute odd parity, tx_ready->0, go to TX_INHIBIT. Transmit has priority over a simultaneous receive start edge; that device frame is discarded.
  - Else a sample event with data=0: go to RX with bit count 0.
  - A sample event with data=1 is ignored.
- RX:
  - Shift 8 data bits, then the parity bit, then the stop bit.
  - On the stop edge: if stop=1 and parity is odd over d0..d7+p, pulse rx_valid and update rx_data in the same cycle. Otherwise pulse rx_err and leave rx_data unchanged.
  - Then return to IDLE.
  - The watchdog counter resets on each sample event. Reaching TIMEOUT_CYCLES pulses rx_err and returns to IDLE.
- TX_INHIBIT:
  - ps2_clk_tx=1 for exactly INHIBIT_CYCLES cycles.
  - Then, in one cycle, set ps2_d_tx=1 (start bit), set ps2_clk_tx=0, and go to TX_DATA.
- TX_DATA:
  - On each sample event output the next bit as ps2_d_tx = ~bit, in order d0..d7, parity, stop.
  - The stop bit is ps2_d_tx=0 (released).
  - After the stop bit is placed, go to TX_ACK.
- TX_ACK:
  - On the next sample event: data=0 pulses tx_done; data=1 pulses tx_err.
  - Then go to TX_RELEASE.
- TX_RELEASE: wait until fclk=1 and synchronised data=1, then return to IDLE.
- Timeouts in TX_DATA/TX_ACK/TX_RELEASE use the same watchdog:
  - Expiry pulses tx_err (TX_DATA/TX_ACK only; TX_RELEASE expiry is silent).
  - Forces both tx outputs to 0 and returns to IDLE.
- ps2_clk_tx/ps2_d_tx are registered outputs; there is no combinational path from the inputs.
- Error and done pulses are mutually exclusive within a cycle.

Optional Feature:
- Macro PS2_GLITCH_FILTER_EN.
- Defined: fclk changes only after FILTER_LEN consecutive equal synchronised samples. Adds FILTER_LEN cycles of latency to the sample event.
- Undefined: fclk is the 2-flop synchroniser output directly; FILTER_LEN is unused.

Test Plan:
- Device frame 0x1C, parity 0, stop 1, 12.5 kHz clock -> one rx_valid pulse with rx_data=0x1C; rx_err=0.
- Device frame 0x1C with parity 1 -> rx_err pulse; rx_data keeps its prior value; rx_valid never asserts.
- tx_data=0xED, tx_valid=1 in IDLE; device model clocks the frame and acks low -> ps2_clk_tx high for exactly 5000 cycles; wire sequence observed is 0, 1,0,1,1,0,1,1,1, parity 1, stop 1; then tx_done pulse and tx_ready=1 again.
- Same transmit, device never acks (data stays high) -> tx_err pulse; both tx outputs 0; tx_ready=1.
- Device clock stops after 4 data bits -> rx_err exactly 100000 cycles after the last falling edge; state returns to IDLE; the next full frame 0xAA is received correctly.
- With PS2_GLITCH_FILTER_EN, 3-cycle low glitches on ps2_clk_rx during a valid frame -> no extra bits; rx_data correct. Without the macro, the same stimulus -> rx_err or corrupt data (bench checks the difference).
